uart_tx_frame: RTL and testbench

//  Parametrised UART transmitter. Serialises one DATA_BITS-wide word per request as

---
 rtl/uart_tx_frame.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Frame: start (0), DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
// Optional feature macro: UART_TX_BREAK_EN adds i_Tx_Break, which holds the line low
// while idle and blocks new requests until released.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
`ifdef UART_TX_BREAK_EN
  input  logic                 i_Tx_Break,
`endif
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam bit            HAS_PAR   = (PARITY_MODE != 0);

  // Reject unsupported configurations at elaboration
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    s_IDLE,
    s_START,
    s_DATA,
    s_PARITY,
    s_STOP,
    s_CLEANUP
  } state_t;

  state_t               state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic [BW-1:0]        bit_nxt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] data_q;
  logic                 parity_bit;
  logic                 break_req;

`ifdef UART_TX_BREAK_EN
  assign break_req = i_Tx_Break;
`else
  assign break_req = 1'b0;
`endif

  // Next data bit index and parity of the latched word
  always_comb begin
    bit_nxt    = bit_idx + BW'(1);
    parity_bit = (PARITY_MODE == 1) ? ~^data_q : ^data_q;
  end

  // Frame sequencer; every output is registered so the line changes on the clock edge
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= s_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
      data_q      <= '0;
      o_Tx_Ready  <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Done   <= 1'b0;
    end else begin
      case (state)
        s_IDLE: begin
          o_Tx_Done   <= 1'b0;
          o_Tx_Active <= 1'b0;
          clk_cnt     <= '0;
          bit_idx     <= '0;
          stop_cnt    <= 1'b0;
          if (break_req) begin
            o_Tx_Serial <= 1'b0;
            o_Tx_Ready  <= 1'b0;
          end else if (i_Tx_DV && o_Tx_Ready) begin
            data_q      <= i_Tx_Data;
            state       <= s_START;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            o_Tx_Ready  <= 1'b0;
          end else begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Ready  <= 1'b1;
          end
        end

        s_START: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt     <= '0;
            state       <= s_DATA;
            o_Tx_Serial <= data_q[0];
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        s_DATA: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              if (HAS_PAR) begin
                state       <= s_PARITY;
                o_Tx_Serial <= parity_bit;
              end else begin
                state       <= s_STOP;
                o_Tx_Serial <= 1'b1;
              end
            end else begin
              bit_idx     <= bit_nxt;
              o_Tx_Serial <= data_q[bit_nxt];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        s_PARITY: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt     <= '0;
            state       <= s_STOP;
            o_Tx_Serial <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        s_STOP: begin
          if (clk_cnt == CLK_LAST) begin
            clk_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              stop_cnt    <= 1'b0;
              state       <= s_CLEANUP;
              o_Tx_Done   <= 1'b1;
              o_Tx_Active <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        s_CLEANUP: begin
          state       <= s_IDLE;
          o_Tx_Done   <= 1'b0;
          o_Tx_Serial <= 1'b1;
          o_Tx_Ready  <= 1'b1;
        end

        default: begin
          state       <= s_IDLE;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
          o_Tx_Ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7E2),
// all at 4 clocks per bit. Outputs are sampled on the falling clock edge.
module tb_uart_tx_frame;

  localparam int unsigned CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       dv   [4];
  logic [8:0] din  [4];
  logic       brk  [4];
  logic       ser  [4];
  logic       act  [4];
  logic       don  [4];
  logic       rdy  [4];

  int unsigned checks;
  int unsigned failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Data(din[0][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk[0]),
`endif
    .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(don[0]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Data(din[1][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk[1]),
`endif
    .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(don[1]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Data(din[2][7:0]),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk[2]),
`endif
    .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(don[2]));

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_7e2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Data(din[3][6:0]),
`ifdef UART_TX_BREAK_EN
    .i_Tx_Break(brk[3]),
`endif
    .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(don[3]));

  // seq holds the line bits in time order, written left to right, right-aligned
  typedef struct packed {
    logic [1:0]  inst;
    logic [8:0]  data;
    logic [15:0] seq;
    logic [4:0]  len;
    logic [6:0]  done_at;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // {serial, active, done, ready} of one instance
  function automatic logic [3:0] outs(input int unsigned i);
    return {ser[i], act[i], don[i], rdy[i]};
  endfunction

  // Send one word, scramble the input after accept, check every cycle up to the idle return
  task automatic run_vec(input int unsigned n, input vec_t v);
    int unsigned i;
    int          idx;
    logic [3:0]  exp;
    i = v.inst;
    @(negedge clk);
    check($sformatf("vec%0d_idle", n), outs(i), 4'b1001);
    dv[i]  = 1'b1;
    din[i] = v.data;
    @(posedge clk);
    #1;
    dv[i]  = 1'b0;
    din[i] = ~v.data;
    for (int k = 1; k <= int'(v.done_at); k++) begin
      @(negedge clk);
      if (k < int'(v.done_at)) begin
        idx = int'(v.len) - 1 - (k - 1) / CPB;
        exp = {v.seq[idx], 3'b100};
      end else begin
        exp = 4'b1010;
      end
      check($sformatf("vec%0d_cyc%0d", n, k), outs(i), exp);
    end
    @(negedge clk);
    check($sformatf("vec%0d_after", n), outs(i), 4'b1001);
  endtask

  initial begin
    logic [15:0] s1;
    logic [15:0] s2;
    logic [3:0]  exp;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dv[i]  = 1'b0;
      din[i] = '0;
      brk[i] = 1'b0;
    end

    vecs[0] = '{inst: 2'd0, data: 9'h0A5, seq: 16'b0101001011,  len: 5'd10, done_at: 7'd41};
    vecs[1] = '{inst: 2'd0, data: 9'h03C, seq: 16'b0001111001,  len: 5'd10, done_at: 7'd41};
    vecs[2] = '{inst: 2'd0, data: 9'h000, seq: 16'b0000000001,  len: 5'd10, done_at: 7'd41};
    vecs[3] = '{inst: 2'd0, data: 9'h0FF, seq: 16'b0111111111,  len: 5'd10, done_at: 7'd41};
    vecs[4] = '{inst: 2'd1, data: 9'h0A5, seq: 16'b01010010101, len: 5'd11, done_at: 7'd45};
    vecs[5] = '{inst: 2'd2, data: 9'h0A5, seq: 16'b01010010111, len: 5'd11, done_at: 7'd45};
    vecs[6] = '{inst: 2'd1, data: 9'h001, seq: 16'b01000000011, len: 5'd11, done_at: 7'd45};
    vecs[7] = '{inst: 2'd2, data: 9'h000, seq: 16'b00000000011, len: 5'd11, done_at: 7'd45};
    vecs[8] = '{inst: 2'd3, data: 9'h007, seq: 16'b01110000111, len: 5'd11, done_at: 7'd45};
    vecs[9] = '{inst: 2'd3, data: 9'h055, seq: 16'b01010101011, len: 5'd11, done_at: 7'd45};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("reset_inst%0d", i), outs(i), 4'b1001);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single frames
    for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

    // Back-to-back with DV held: 0x5A then 0xC3, one cleanup + one idle cycle between
    s1 = 16'b0010110101;
    s2 = 16'b0110000111;
    @(negedge clk);
    check("b2b_idle", outs(0), 4'b1001);
    dv[0]  = 1'b1;
    din[0] = 9'h05A;
    @(posedge clk);
    #1;
    din[0] = 9'h0C3;
    for (int k = 1; k <= 86; k++) begin
      @(negedge clk);
      if (k <= 40)      exp = {s1[9 - (k - 1) / CPB], 3'b100};
      else if (k == 41) exp = 4'b1010;
      else if (k == 42) exp = 4'b1001;
      else if (k <= 82) exp = {s2[9 - (k - 43) / CPB], 3'b100};
      else if (k == 83) exp = 4'b1010;
      else              exp = 4'b1001;
      check($sformatf("b2b_cyc%0d", k), outs(0), exp);
      if (k == 43) dv[0] = 1'b0;
    end

    // Reset during data bit 3 aborts the frame at once
    @(negedge clk);
    dv[0]  = 1'b1;
    din[0] = 9'h000;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    repeat (18) @(negedge clk);
    check("rst_mid_before", outs(0), 4'b0100);
    rst_n = 1'b0;
    #1;
    check("rst_mid_abort", outs(0), 4'b1001);
    @(negedge clk);
    check("rst_mid_held", outs(0), 4'b1001);
    rst_n = 1'b1;
    run_vec(100, vecs[1]);

`ifdef UART_TX_BREAK_EN
    // Break in idle: line low, not ready, DV ignored; release restores idle
    @(negedge clk);
    brk[0] = 1'b1;
    dv[0]  = 1'b1;
    din[0] = 9'h0FF;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("brk_cyc%0d", k), outs(0), 4'b0000);
    end
    brk[0] = 1'b0;
    dv[0]  = 1'b0;
    @(negedge clk);
    check("brk_release", outs(0), 4'b1001);
    @(negedge clk);
    check("brk_idle", outs(0), 4'b1001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
